// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } sw_state_t;

  localparam int MS_W   = 10;
  localparam int S_W    = 7;
  localparam int S_MAX  = 99;
  localparam int MS_MAX = 999;

endpackage

// File: rtl/btn_debounce.sv
// Key conditioning: 2-flop synchronizer, tick-based debouncer, press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic tick,
  output logic press
);

  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;

  logic          s1, s2;
  logic          db, db_d;
  logic [CW-1:0] cnt;

  // Bring the raw key into the clk domain; idle level is released (1).
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed on DEBOUNCE_MS consecutive ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db   <= 1'b1;
      db_d <= 1'b1;
      cnt  <= '0;
    end else begin
      db_d <= db;
      if (tick) begin
        if (s2 != db) begin
          if (cnt == CW'(DEBOUNCE_MS - 1)) begin
            db  <= s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

  // Falling edge of the debounced level is a press; release is ignored.
  assign press = db_d & ~db;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: key handling, tick prescaler, lap capture, display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_ss_n,
  input  logic            btn_lr_n,
  input  logic [MS_W-1:0] ms_in,
  input  logic [S_W-1:0]  s_in,
  output logic            cnt_en,
  output logic            cnt_clr_n,
  output logic [MS_W-1:0] disp_ms,
  output logic [S_W-1:0]  disp_s,
  output logic [1:0]      state,
  output logic            running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]   presc;
  logic            tick;
  logic            ss_ev, lr_ev;
  logic            sat;
  sw_state_t       st;
  logic [MS_W-1:0] lap_ms;
  logic [S_W-1:0]  lap_s;

  // Free-running prescaler producing a one-cycle tick every DIV clocks.
  always_ff @(posedge clk) begin
    if (!rst)      presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign tick = (presc == PW'(DIV - 1));

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ss (
    .clk(clk), .rst(rst), .btn_n(btn_ss_n), .tick(tick), .press(ss_ev)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_lr (
    .clk(clk), .rst(rst), .btn_n(btn_lr_n), .tick(tick), .press(lr_ev)
  );

  assign sat     = (s_in == S_W'(S_MAX)) && (ms_in == MS_W'(MS_MAX));
  assign running = (st == RUNNING) || (st == LAP);
  // Counter must not advance past 99.999; the FSM pauses on that same tick.
  assign cnt_en  = tick & running & ~sat;

  // Main FSM; start/stop wins over lap/reset, saturation wins over both.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= IDLE;
      cnt_clr_n <= 1'b0;
      lap_ms    <= '0;
      lap_s     <= '0;
    end else begin
      cnt_clr_n <= 1'b1;
      case (st)
        IDLE: begin
          if (ss_ev)      st <= RUNNING;
          else if (lr_ev) cnt_clr_n <= 1'b0;
        end
        RUNNING: begin
          if (tick && sat) st <= PAUSED;
          else if (ss_ev)  st <= PAUSED;
          else if (lr_ev) begin
            st     <= LAP;
            lap_ms <= ms_in;
            lap_s  <= s_in;
          end
        end
        LAP: begin
          if (tick && sat) st <= PAUSED;
          else if (ss_ev)  st <= PAUSED;
          else if (lr_ev)  st <= RUNNING;
        end
        PAUSED: begin
          if (ss_ev) st <= RUNNING;
          else if (lr_ev) begin
            st        <= IDLE;
            cnt_clr_n <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state   = st;
  assign disp_ms = (st == LAP) ? lap_ms : ms_in;
  assign disp_s  = (st == LAP) ? lap_s  : s_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV=10, DEBOUNCE_MS=2.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss_n, btn_lr_n;
  logic [9:0] ms_in;
  logic [6:0] s_in;
  logic       cnt_en, cnt_clr_n, running;
  logic [9:0] disp_ms;
  logic [6:0] disp_s;
  logic [1:0] state;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_MS(2)) dut (
    .clk(clk), .rst(rst), .btn_ss_n(btn_ss_n), .btn_lr_n(btn_lr_n),
    .ms_in(ms_in), .s_in(s_in), .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n),
    .disp_ms(disp_ms), .disp_s(disp_s), .state(state), .running(running)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference prescaler phase: tick expected when m==9.
  int m = 0;
  always @(posedge clk) begin
    if (!rst) m <= 0;
    else      m <= (m == 9) ? 0 : m + 1;
  end

  // Running tallies sampled on the falling edge.
  int clr_cnt = 0;
  int en_cnt  = 0;
  int en_err  = 0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (cnt_clr_n === 1'b0) clr_cnt++;
      if (cnt_en === 1'b1) begin
        en_cnt++;
        if (m != 9 || running !== 1'b1) en_err++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // key: 0=ss, 1=lr, 2=both together, 3=no press (just wait)
  task automatic press(input int key);
    @(negedge clk);
    if (key == 3) begin
      repeat (20) @(negedge clk);
    end else begin
      if (key != 1) btn_ss_n = 1'b0;
      if (key != 0) btn_lr_n = 1'b0;
      repeat (40) @(negedge clk);
      btn_ss_n = 1'b1;
      btn_lr_n = 1'b1;
      repeat (40) @(negedge clk);
    end
  endtask

  typedef struct {
    int    key;
    int    ms;
    int    s;
    int    st;
    int    dms;
    int    ds;
    int    clr;
    string name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int base_clr, base_en, i;
    bit hit;

    tbl[0] = '{1, 123, 4, 3, 123, 4, 0, "run_lr_lap"};
    tbl[1] = '{3, 500, 7, 3, 123, 4, 0, "lap_hold"};
    tbl[2] = '{1, 200, 8, 1, 200, 8, 0, "lap_lr_run"};
    tbl[3] = '{0, 300, 9, 2, 300, 9, 0, "run_ss_pause"};
    tbl[4] = '{0, 301, 9, 1, 301, 9, 0, "pause_ss_run"};
    tbl[5] = '{0, 302, 9, 2, 302, 9, 0, "run_ss_pause2"};
    tbl[6] = '{1, 303, 9, 0, 303, 9, 1, "pause_lr_idle"};
    tbl[7] = '{1, 0,   0, 0, 0,   0, 1, "idle_lr_clr"};
    tbl[8] = '{0, 10,  1, 1, 10,  1, 0, "idle_ss_run"};
    tbl[9] = '{2, 44,  2, 2, 44,  2, 0, "both_ss_wins"};

    rst = 1'b0; btn_ss_n = 1'b1; btn_lr_n = 1'b1; ms_in = '0; s_in = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_clr_n", cnt_clr_n, 0);
    chk("rst_cnt_en", cnt_en, 0);
    rst = 1'b1;
    base_en = en_cnt;
    repeat (50) @(negedge clk);
    chk("idle_state", state, 0);
    chk("idle_clr_n", cnt_clr_n, 1);
    chk("idle_no_en", en_cnt - base_en, 0);

    // One-tick glitch must not register
    btn_ss_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_ss_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_ignored", state, 0);

    // Long press gives exactly one event; cnt_en every 10 cycles
    press(0);
    chk("ss_run", state, 1);
    base_en = en_cnt;
    repeat (40) @(negedge clk);
    chk("en_per_40", en_cnt - base_en, 4);

    // Table-driven transitions
    for (i = 0; i < 10; i++) begin
      ms_in = tbl[i].ms[9:0];
      s_in  = tbl[i].s[6:0];
      base_clr = clr_cnt;
      press(tbl[i].key);
      chk({tbl[i].name, "_state"}, state, tbl[i].st);
      chk({tbl[i].name, "_dms"}, disp_ms, tbl[i].dms);
      chk({tbl[i].name, "_ds"}, disp_s, tbl[i].ds);
      chk({tbl[i].name, "_clr"}, clr_cnt - base_clr, tbl[i].clr);
    end

    // Reset in the middle of LAP
    press(0);
    ms_in = 10'd321; s_in = 7'd3;
    press(1);
    chk("lap_entry", state, 3);
    ms_in = 10'd55; s_in = 7'd6;
    @(negedge clk);
    chk("lap_disp_held", disp_ms, 321);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_state", state, 0);
    chk("midrst_dms", disp_ms, 55);
    chk("midrst_ds", disp_s, 6);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Saturation at 99.999 on a tick
    ms_in = 10'd1; s_in = 7'd1;
    press(0);
    chk("sat_pre_run", state, 1);
    ms_in = 10'd999; s_in = 7'd99;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (m == 9) hit = 1'b1;
    end
    chk("sat_tick_found", hit, 1);
    chk("sat_no_en", cnt_en, 0);
    chk("sat_still_run", state, 1);
    @(posedge clk); #1;
    chk("sat_paused", state, 2);

    chk("en_only_on_tick_running", en_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 1000, counting-tick rate; DIV = CLK_HZ/TICK_HZ (50_000 at defaults).
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20, number of ticks a button must stay stable.
REQ-004 SHALL have ports:
 - clk  in  1  single system clock, rising edge.
 - rst  in  1  reset, synchronous, active-low.
 - btn_ss_n  in  1  raw start/stop key, active-low, asynchronous to clk.
 - btn_lr_n  in  1  raw lap/reset key, active-low, asynchronous to clk.
 - ms_in  in  10  live millisecond count from the counter.
 - s_in  in  7  live seconds count from the counter.
 - cnt_en  out  1  one-cycle count-enable pulse to the counter.
 - cnt_clr_n  out  1  active-low clear to the counter.
 - disp_ms  out  10  millisecond value to display.
 - disp_s  out  7  seconds value to display.
 - state  out  2  current FSM state encoding.
 - running  out  1  high in RUNNING or LAP.

Function
REQ-005 Each key SHALL pass a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it on DEBOUNCE_MS consecutive ticks.
REQ-006 A press event SHALL be a one-cycle pulse on the 1->0 transition of the debounced level; release SHALL produce no event.
REQ-007 A free-running prescaler SHALL count 0..DIV-1 and assert tick for one cycle when it equals DIV-1, then wrap to 0.
REQ-008 cnt_en SHALL equal tick while state is RUNNING or LAP, and 0 otherwise.
REQ-009 States SHALL be IDLE=0, RUNNING=1, PAUSED=2, LAP=3.
REQ-010 IDLE: ss event -> RUNNING; lr event -> stay IDLE, pulse cnt_clr_n low for one cycle.
REQ-011 RUNNING: ss event -> PAUSED; lr event -> LAP, latching ms_in/s_in into the lap registers in the same cycle.
REQ-012 LAP: ss event -> PAUSED; lr event -> RUNNING.
REQ-013 PAUSED: ss event -> RUNNING; lr event -> IDLE, pulse cnt_clr_n low for one cycle.
REQ-014 disp_ms/disp_s SHALL show the lap registers in LAP and ms_in/s_in combinationally in all other states.
REQ-015 ss and lr events in the same cycle: ss SHALL be taken, lr discarded.
REQ-016 Saturation: in RUNNING or LAP with s_in==99 and ms_in==999 on a tick cycle, cnt_en SHALL stay 0 and state SHALL go to PAUSED.
REQ-017 State transitions SHALL take effect on the clock edge following the event (1-cycle latency); cnt_clr_n SHALL be registered.

Reset
REQ-018 While rst==0 at a rising clk edge: state=IDLE, cnt_en=0, cnt_clr_n=0, lap registers=0, prescaler=0, debounced levels=1 (released), synchronizers=1, debounce counters=0.
REQ-019 On the first edge with rst==1, cnt_clr_n SHALL return to 1; reset mid-run SHALL abandon any pending event.

Structure
REQ-020 A shared package stopwatch_pkg SHALL hold the state enum, width constants (MS_W=10, S_W=7) and the saturation limits (99, 999).
REQ-021 Sync+debounce+edge-detect SHALL be one sub-module, btn_debounce, instantiated once per key and sharing the tick.
REQ-022 The prescaler SHALL be 16 bits wide at default parameters, sized by $clog2(DIV) in general.

Verification (bench parameters: CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DEBOUNCE_MS=2)
REQ-023 Reset then 50 idle cycles -> state=0, cnt_en never high, cnt_clr_n=0 during reset and 1 afterwards.
REQ-024 btn_ss_n held low for 40 cycles -> exactly one ss event, state=1, cnt_en pulses every 10 cycles; a 1-tick glitch -> no event.
REQ-025 RUNNING, ms_in=123, s_in=4, lr press -> state=3, disp=4/123 held while ms_in changes; second lr press -> state=1, display live.
REQ-026 PAUSED, lr press -> state=0, cnt_clr_n low for exactly one cycle.
REQ-027 RUNNING, s_in=99 and ms_in=999 at a tick -> cnt_en stays 0 and state=2 on the next edge.
REQ-028 ss and lr events in the same cycle from RUNNING -> state=2 and no lap latch; rst low mid-LAP -> state=0 and disp_* live on the next edge.
